re_log_mac: RTL
===============

RE_LOG_MAC -- requirements
Module: re_log_mac

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- K_LENGTH, 5, log2 integer-part width per operand.
- M1_LENGTH, 8, log2 fraction width per operand; the leading one is implicit.
- ACC_LENGTH, 64, accumulator and result width.

REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, operand beat valid.
- in_ready, out, 1, beat accepted when in_valid and in_ready are both high at a rising edge.
- ka, in, K_LENGTH, operand A leading-one position.
- ma, in, M1_LENGTH, operand A fraction.
- za, in, 1, operand A is zero.
- kb, in, K_LENGTH, operand B leading-one position.
- mb, in, M1_LENGTH, operand B fraction.
- zb, in, 1, operand B is zero.
- in_last, in, 1, final beat of the current dot-product group.
- out_valid, out, 1, result valid.
- out_ready, in, 1, result consumed when out_valid and out_ready are both high at a rising edge.
- out_acc, out, ACC_LENGTH, accumulated group sum.
- out_ovf, out, 1, the group accumulation carried out of ACC_LENGTH bits.

REQ-003 SHALL use one clock, clk, with synchronous active-high reset rst.

Function
REQ-004 SHALL implement three register stages: S1 log-sum, S2 antilog, S3 accumulate/result.
REQ-005 S1 SHALL compute fs = ma + mb (M1_LENGTH+1 bits) and ks = ka + kb + fs[M1_LENGTH] (K_LENGTH+1 bits), and register ks, fs[M1_LENGTH-1:0], z = za|zb, last and valid.
REQ-006 S2 SHALL compute prod = ({1'b1, fs} << ks) >> M1_LENGTH, truncated to ACC_LENGTH bits, with prod forced to 0 when z=1; it SHALL register prod, last and valid.
REQ-007 S3, on an S2-valid beat, SHALL form sum = acc + prod with carry c, and SHALL set the sticky group overflow flag ovf_g |= c.
REQ-008 On a non-last beat, S3 SHALL update acc with the ACC_LENGTH-bit sum, wrapping modulo 2^ACC_LENGTH.
REQ-009 On a last beat, S3 SHALL set out_acc=sum, out_ovf=ovf_g|c and out_valid=1, then clear acc=0 and ovf_g=0.
REQ-010 SHALL define adv = !(out_valid && !out_ready), and all stages SHALL advance only when adv=1; in_ready SHALL equal adv when rst=0.
REQ-011 When adv=0, S1, S2, acc, out_acc and out_ovf SHALL hold.
REQ-012 When out_valid && out_ready and no last beat reaches S3 in that cycle, out_valid SHALL drop to 0.
REQ-013 When out_valid && out_ready and a last beat reaches S3 in the same cycle, out_acc and out_ovf SHALL load the new result and out_valid SHALL stay 1.
REQ-014 Latency: a beat accepted at edge n SHALL reach S1 at n, S2 at n+1 and S3 at n+2; for a last beat, out_valid SHALL be high after edge n+2.
REQ-015 Throughput SHALL be one beat per cycle when out_ready=1.
REQ-016 Bubbles (in_valid=0) SHALL propagate as invalid stages and SHALL NOT modify acc.
REQ-017 A single-beat group (in_last=1 on its only beat) SHALL produce out_acc=prod.
REQ-018 out_acc and out_ovf SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-019 While rst=1, SHALL clear S1/S2 valids, acc, ovf_g, out_acc, out_ovf and out_valid to 0, and SHALL drive in_ready=0.
REQ-020 rst asserted mid-group SHALL discard all in-flight beats and any partial sum; the first beat accepted after reset SHALL start a new group.
REQ-021 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (M1_LENGTH=8)
REQ-022 Single beat ka=kb=1, ma=mb=0x80, in_last=1 (3*3) -> out_acc=8 and out_ovf=0, three edges after acceptance.
REQ-023 Group of three beats (5*1, 4*4, 0*7 with za=1), last on the third beat, out_ready=1 -> out_acc=5+16+0=21 and out_ovf=0.
REQ-024 Two beats with ka=kb=31 and ma=mb=0xFF -> each prod=0xFF00_0000_0000_0000; result out_acc=0xFE00_0000_0000_0000 and out_ovf=1; the next group starts with ovf_g=0.
REQ-025 out_ready held 0 for 5 cycles with out_valid=1 -> in_ready=0, and out_acc, out_ovf and the pipeline hold; after out_ready rises, the following group's results appear in order with no beat lost or duplicated.
REQ-026 Back-to-back single-beat last groups with out_ready=1 -> out_valid stays 1 every cycle and out_acc updates each cycle.
REQ-027 rst pulsed for one cycle after two non-last beats -> out_valid=0 and acc=0; a following single beat 4*4 with in_last=1 -> out_acc=16.

Source files
------------

// File: rtl/re_log_mac.sv
// re_log_mac: log-domain multiply-accumulate over dot-product groups.
// Stages: S1 log-sum, S2 antilog, S3 accumulate/result; result backpressure stalls every stage.
module re_log_mac #(
    parameter int unsigned K_LENGTH   = 5,
    parameter int unsigned M1_LENGTH  = 8,
    parameter int unsigned ACC_LENGTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K_LENGTH-1:0]   ka,
    input  logic [M1_LENGTH-1:0]  ma,
    input  logic                  za,
    input  logic [K_LENGTH-1:0]   kb,
    input  logic [M1_LENGTH-1:0]  mb,
    input  logic                  zb,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_LENGTH-1:0] out_acc,
    output logic                  out_ovf
);
    localparam int unsigned KS_W = K_LENGTH + 1;

    logic                  adv;
    logic [M1_LENGTH:0]    fs;
    logic [KS_W-1:0]       ks;

    logic                  s1_valid;
    logic                  s1_last;
    logic                  s1_z;
    logic [KS_W-1:0]       s1_ks;
    logic [M1_LENGTH-1:0]  s1_fs;

    logic                  s2_valid;
    logic                  s2_last;
    logic [ACC_LENGTH-1:0] s2_prod;

    logic [ACC_LENGTH-1:0] acc;
    logic                  ovf_g;

    logic [ACC_LENGTH-1:0] mant;
    logic [ACC_LENGTH-1:0] prod;
    logic [ACC_LENGTH:0]   sum;

    // A held result with no consumer freezes the whole pipeline.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv && !rst;

    assign fs = {1'b0, ma} + {1'b0, mb};
    assign ks = {1'b0, ka} + {1'b0, kb} + {{K_LENGTH{1'b0}}, fs[M1_LENGTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_z     <= 1'b0;
            s1_ks    <= '0;
            s1_fs    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_z     <= za | zb;
            s1_ks    <= ks;
            s1_fs    <= fs[M1_LENGTH-1:0];
        end
    end

    // Antilog: (1.fs << ks) >> M1_LENGTH, split so no intermediate wider than the result.
    assign mant = ACC_LENGTH'({1'b1, s1_fs});

    always_comb begin
        prod = '0;
        if (!s1_z) begin
            if (32'(s1_ks) >= M1_LENGTH) begin
                prod = mant << (32'(s1_ks) - M1_LENGTH);
            end else begin
                prod = mant >> (M1_LENGTH - 32'(s1_ks));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_prod  <= prod;
        end
    end

    assign sum = {1'b0, acc} + {1'b0, s2_prod};

    // A last beat arriving while the old result is consumed reloads out_acc without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            ovf_g     <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            if (s2_valid && s2_last) begin
                out_acc   <= sum[ACC_LENGTH-1:0];
                out_ovf   <= ovf_g | sum[ACC_LENGTH];
                out_valid <= 1'b1;
                acc       <= '0;
                ovf_g     <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                if (s2_valid) begin
                    acc   <= sum[ACC_LENGTH-1:0];
                    ovf_g <= ovf_g | sum[ACC_LENGTH];
                end
            end
        end
    end

endmodule
